// File: rtl/seq_det_pkg.sv
// Shared defaults and parameter legality check for the serial sequence detector.
// No logic of its own; it only supplies constants.
package seq_det_pkg;

    localparam int         DEF_PAT_W   = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b1101;
    localparam int         DEF_CNT_W   = 8;

    function automatic bit pat_w_legal(input int w);
        return (w >= 2) && (w <= 32);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that holds at all-ones; cnt updates one cycle after inc.
// Latency: 1 cycle. Backpressure: none, inc is taken every cycle it is high.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a Mealy match pulse (0 cycles latency); no backpressure, bits only consumed when en=1.
// Optional saturating match counter (match_cnt) is built only when SEQ_DET_COUNT_EN is defined.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in,
`ifdef SEQ_DET_COUNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             out
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    generate
        if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
            $error("seq_detect_param: PAT_W must be in 2..32");
        end
    endgenerate

    logic [PAT_W-2:0]  hist_q;
    logic [PAT_W-2:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [PAT_W-1:0]  cand;
    logic              full;
    logic              hit;

    assign cand = {hist_q, in};
    assign full = (fill_q == FILL_FULL);
    // rst is folded in so the pulse is suppressed for the whole reset cycle.
    assign hit  = rst & en & full & (cand == PATTERN);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (en) begin
            hist_d = cand[PAT_W-2:0];
            if (hit && (OVERLAP == 0)) begin
                fill_d = '0;
            end else if (!full) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    assign out = hit;

`ifdef SEQ_DET_COUNT_EN
    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit),
        .cnt (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Drives three detector configurations (1101 overlap, 1101 non-overlap, A5 8-bit) with shared stimulus:
// a directed vector table, a counter-saturation sequence, then random bits checked against a queue model.
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic in_b = 1'b0;
    logic o_ov, o_nov, o_w;
`ifdef SEQ_DET_COUNT_EN
    logic [1:0] cnt_ov;
    logic [7:0] cnt_nov;
    logic [7:0] cnt_w;
`endif

    always #5 clk = ~clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2)) u_ov (
        .clk(clk), .rst(rst), .en(en), .in(in_b),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_ov),
`endif
        .out(o_ov));

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .en(en), .in(in_b),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_nov),
`endif
        .out(o_nov));

    seq_detect_param #(.PAT_W(8), .PATTERN(8'hA5), .OVERLAP(1), .CNT_W(8)) u_w (
        .clk(clk), .rst(rst), .en(en), .in(in_b),
`ifdef SEQ_DET_COUNT_EN
        .match_cnt(cnt_w),
`endif
        .out(o_w));

    typedef struct packed {
        logic r, e, i;
        logic x_ov, x_nov, x_w;
    } vec_t;

    vec_t tab[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: bits received since reset (or since the last hit when non-overlapping).
    bit q_ov[$];
    bit q_nov[$];
    bit q_w[$];
    int m_cnt = 0;

    function automatic bit model_hit(input bit q[$], input int w, input logic [31:0] pat, input bit b);
        bit v;
        if (q.size() < w - 1) return 1'b0;
        for (int k = 0; k < w; k++) begin
            v = (k == w - 1) ? b : q[q.size() - (w - 1) + k];
            if (v != pat[w - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, e, i, a, b, c);
        vec_t v;
        v = '{r: r, e: e, i: i, x_ov: a, x_nov: b, x_w: c};
        tab.push_back(v);
    endtask

    // bits are given oldest-first from the MSB; masks mark the cycles expected to pulse.
    task automatic add_stream(input logic [31:0] bits, input int n,
                              input logic [31:0] m_ov, input logic [31:0] m_nov, input logic [31:0] m_w);
        for (int k = 0; k < n; k++) begin
            add(1'b1, 1'b1, bits[n-1-k], m_ov[n-1-k], m_nov[n-1-k], m_w[n-1-k]);
        end
    endtask

    task automatic step(input logic r, e, i, input logic x_ov, x_nov, x_w, input bit use_tab);
        bit h_ov, h_nov, h_w;
        @(negedge clk);
        rst = r; en = e; in_b = i;
        #1;
        h_ov  = r && e && model_hit(q_ov, 4, 32'hD, i);
        h_nov = r && e && model_hit(q_nov, 4, 32'hD, i);
        h_w   = r && e && model_hit(q_w, 8, 32'hA5, i);
        if (use_tab) begin
            chk("tab_out_ov", {31'd0, o_ov}, {31'd0, x_ov});
            chk("tab_out_nov", {31'd0, o_nov}, {31'd0, x_nov});
            chk("tab_out_w", {31'd0, o_w}, {31'd0, x_w});
        end else begin
            chk("rnd_out_ov", {31'd0, o_ov}, {31'd0, h_ov});
            chk("rnd_out_nov", {31'd0, o_nov}, {31'd0, h_nov});
            chk("rnd_out_w", {31'd0, o_w}, {31'd0, h_w});
        end
`ifdef SEQ_DET_COUNT_EN
        chk("cnt_ov", {30'd0, cnt_ov}, m_cnt);
`endif
        if (!r) begin
            q_ov.delete(); q_nov.delete(); q_w.delete();
            m_cnt = 0;
        end else if (e) begin
            q_ov.push_back(i);
            if (h_nov) q_nov.delete(); else q_nov.push_back(i);
            q_w.push_back(i);
            while (q_ov.size() > 40) void'(q_ov.pop_front());
            while (q_nov.size() > 40) void'(q_nov.pop_front());
            while (q_w.size() > 40) void'(q_w.pop_front());
            if (h_ov && m_cnt < 3) m_cnt++;
        end
    endtask

    initial begin
        int exp_cnt[5];
        int n_hit;
        logic [15:0] sat_bits;
        logic r, e, i;

        // Reset state, with inputs that would otherwise be consumed.
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Overlap hits on bits 4,7,11; non-overlap on 4,11 only.
        add_stream(32'b11011011101, 11, 32'b00010010001, 32'b00010000001, 32'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Wide pattern completes on the 8th bit.
        add_stream(32'b10100101, 8, 32'b0, 32'b0, 32'b00000001);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Reset mid-sequence discards the 1,1,0 prefix.
        add_stream(32'b110, 3, 32'b0, 32'b0, 32'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_stream(32'b1101, 4, 32'b0001, 32'b0001, 32'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Match spanning an enable gap with in toggling.
        add_stream(32'b11, 2, 32'b0, 32'b0, 32'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_stream(32'b01, 2, 32'b01, 32'b01, 32'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // Seven wide bits, then the completing bit with en=0 gives no pulse.
        add_stream(32'b1010010, 7, 32'b0, 32'b0, 32'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        foreach (tab[k]) begin
            step(tab[k].r, tab[k].e, tab[k].i, tab[k].x_ov, tab[k].x_nov, tab[k].x_w, 1'b1);
        end

`ifdef SEQ_DET_COUNT_EN
        // Five overlapping matches into a 2-bit counter; idle cycles let the count be read back.
        exp_cnt = '{1, 2, 3, 3, 3};
        sat_bits = 16'b1101101101101101;
        n_hit = 0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 1'b1, sat_bits[15-k], 1'b0, 1'b0, 1'b0, 1'b0);
            if (k >= 3 && (k % 3) == 0) begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("cnt_sat", {30'd0, cnt_ov}, exp_cnt[n_hit]);
                n_hit++;
            end
        end
`endif

        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 63) != 0);
            e = ($urandom_range(0, 3) != 0);
            i = $urandom_range(0, 1) != 0;
            step(r, e, i, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 4: pattern length in bits; legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 4'b1101: target sequence; the MSB is the oldest bit, the LSB is the newest bit.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-004 SHALL have parameter CNT_W, default 8: width of the match counter.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port en, input, 1 bit: sample qualifier; `in` is consumed only when en=1.
REQ-008 SHALL have port in, input, 1 bit: serial data bit.
REQ-009 SHALL have port out, output, 1 bit: Mealy match pulse.
REQ-010 SHALL have port match_cnt, output, CNT_W bits: saturating match count; present only when SEQ_DET_COUNT_EN is defined.

Function
REQ-011 SHALL hold a history register hist[PAT_W-2:0] and a fill counter fill with range 0..PAT_W-1.
REQ-012 SHALL form the candidate window cand = {hist, in} combinationally.
REQ-013 SHALL drive out = en & (fill == PAT_W-1) & (cand == PATTERN): combinational Mealy output with zero latency, asserted in the same cycle as the completing bit.
REQ-014 SHALL, when en=1 and there is no hit, shift in into hist and set fill to min(fill+1, PAT_W-1).
REQ-015 SHALL, on a hit with OVERLAP=1, shift in into hist and leave fill at PAT_W-1, so the suffix can begin the next match.
REQ-016 SHALL, on a hit with OVERLAP=0, clear fill to 0; hist contents then do not matter.
REQ-017 SHALL, when en=0, hold hist and fill unchanged and force out=0; a match may span enable gaps.
REQ-018 SHALL NOT assert out until PAT_W qualified bits have been received since reset, or since the last hit when OVERLAP=0.
REQ-019 SHALL compare all PAT_W bits, with no don't-care bits.

Reset
REQ-020 SHALL, on rst=0 at a rising clk edge, set hist=0, fill=0, and (when the counter is compiled in) match_cnt=0.
REQ-021 SHALL force out=0 while rst=0, regardless of en and in.
REQ-022 SHALL discard any partial match in progress when reset is applied mid-sequence.

Configuration
REQ-023 SHALL gate the counter with macro SEQ_DET_COUNT_EN.
REQ-024 SHALL, when SEQ_DET_COUNT_EN is defined, increment match_cnt by 1 on every cycle with out=1, saturating at 2^CNT_W-1.
REQ-025 SHALL, when SEQ_DET_COUNT_EN is undefined, have no match_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-026 SHALL place in package seq_det_pkg: the default PAT_W/PATTERN/CNT_W constants and a legality check (PAT_W >= 2).
REQ-027 SHALL implement the counter as sub-module sat_counter (params W; ports clk, rst, inc, cnt), instantiated only under SEQ_DET_COUNT_EN.
REQ-028 SHALL keep the whole block between 120 and 400 lines of RTL, with no memories and no multicycle paths.

Verification
REQ-029 SHALL cover overlap mode: with OVERLAP=1, PATTERN=1101, en=1, input 1,1,0,1,1,0,1 -> out=1 on the 4th and 7th bits only.
REQ-030 SHALL cover non-overlap mode: with OVERLAP=0, the same stream plus an extra 1,1,0,1 -> out=1 on the 4th and 11th bits, and not on the 7th.
REQ-031 SHALL cover enable gaps: bits 1,1 then en=0 for 3 cycles (in toggling), then 0,1 -> out=1 on the final bit only, and out=0 during the gap.
REQ-032 SHALL cover reset mid-sequence: 1,1,0, rst=0 for one cycle, then 1 -> out stays 0; a following 1,0,1 -> out=1 on its final bit.
REQ-033 SHALL cover counter saturation: with SEQ_DET_COUNT_EN defined and CNT_W=2, five overlapping matches of 1101101101101101 -> match_cnt reads 1,2,3,3,3 after each match.
REQ-034 SHALL cover a wide pattern: PAT_W=8, PATTERN=8'hA5 -> out=1 exactly at the 8th bit of 10100101, and a stream of 7 bits followed by en=0 -> no pulse.
